// File: rtl/repetition_matcher_if.sv
// ----------------------------------------------------------------------------
// repetition_matcher_if
//   Bundles the event inputs and observation outputs of repetition_matcher.
//   Handshake: there is no valid/ready pair; every input is sampled on every
//   rising clock edge, and outputs are registered and valid for a whole cycle.
//
//   Signals:
//     clr      - synchronous clear of progress, state and hits (master -> slave)
//     a, b     - sampled events (master -> slave)
//     match    - one-cycle pulse per completed pattern (slave -> master)
//     busy     - goto attempt armed (slave -> master)
//     progress - repetitions counted toward N (slave -> master)
//     hits     - saturating count of match pulses (slave -> master)
// ----------------------------------------------------------------------------
interface repetition_matcher_if #(
    parameter int HIT_W = 8
);
    logic             clr;
    logic             a;
    logic             b;
    logic             match;
    logic             busy;
    logic [3:0]       progress;
    logic [HIT_W-1:0] hits;

    modport master (
        output clr, a, b,
        input  match, busy, progress, hits
    );

    modport slave (
        input  clr, a, b,
        output match, busy, progress, hits
    );
endinterface

// File: rtl/repetition_matcher.sv
// ----------------------------------------------------------------------------
// repetition_matcher
//   Recognises a repetition pattern on sampled events.
//     KIND=0 : consecutive repetition a[*N], overlapping matches.
//     KIND=1 : goto repetition a ##1 b[->N], non-reentrant single attempt.
//   match is registered: it pulses in the cycle after the completing sample.
//
//   Ports:
//     clk         - clock, all state updates on its rising edge
//     rst_n       - asynchronous active-low reset
//     bus         - repetition_matcher_if slave (clr, a, b, match, busy,
//                   progress, hits)
//     dbg_state_o - current FSM state (0 = IDLE, 1 = ARMED)
// ----------------------------------------------------------------------------
module repetition_matcher #(
    parameter int KIND  = 0,
    parameter int N     = 5,
    parameter int HIT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    repetition_matcher_if.slave  bus,
    output logic                 dbg_state_o
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ARMED = 1'b1;

    localparam logic [3:0]       N_L     = 4'(N);
    localparam logic [3:0]       N_M1    = 4'(N - 1);
    localparam logic [HIT_W-1:0] HIT_MAX = '1;

    logic [0:0]       state_q, state_d;
    logic [3:0]       prog_q,  prog_d;
    logic             match_q, match_d;
    logic [HIT_W-1:0] hits_q,  hits_d;

    always_comb begin
        state_d = state_q;
        prog_d  = prog_q;
        match_d = 1'b0;
        hits_d  = hits_q;

        if (bus.clr) begin
            // clr outranks any event sampled in the same cycle
            state_d = IDLE;
            prog_d  = '0;
            hits_d  = '0;
        end else begin
            if (KIND == 0) begin
                if (bus.a) begin
                    // Completing when the run was already N-1 or saturated at N
                    // gives one pulse per extra a=1 (overlapping matches).
                    match_d = (prog_q == N_M1) || (prog_q == N_L);
                    prog_d  = (prog_q == N_L) ? N_L : prog_q + 4'd1;
                end else begin
                    prog_d = '0;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        // b in the arming cycle is deliberately not counted
                        if (bus.a) begin
                            state_d = ARMED;
                            prog_d  = '0;
                        end
                    end
                    ARMED: begin
                        // a is ignored while armed: one attempt at a time
                        if (bus.b) begin
                            if (prog_q == N_M1) begin
                                state_d = IDLE;
                                prog_d  = '0;
                                match_d = 1'b1;
                            end else begin
                                prog_d = prog_q + 4'd1;
                            end
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        prog_d  = '0;
                    end
                endcase
            end

            // hits moves on the same edge that raises match
            if (match_d && (hits_q != HIT_MAX)) begin
                hits_d = hits_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            prog_q  <= '0;
            match_q <= 1'b0;
            hits_q  <= '0;
        end else begin
            state_q <= state_d;
            prog_q  <= prog_d;
            match_q <= match_d;
            hits_q  <= hits_d;
        end
    end

    assign bus.match    = match_q;
    assign bus.busy     = (KIND == 1) && (state_q == ARMED);
    assign bus.progress = prog_q;
    assign bus.hits     = hits_q;
    assign dbg_state_o  = state_q[0];

endmodule

// File: doc/repetition_matcher.md
REPETITION_MATCHER -- requirements
Module: repetition_matcher

Interface
REQ-001 SHALL have parameter KIND, default 0, selecting the pattern: 0 = consecutive (a[*N]), 1 = goto (a ##1 b[->N]).
REQ-002 SHALL have parameter N, default 5, the repetition count, legal range 1..15.
REQ-003 SHALL have parameter HIT_W, default 8, the width of the hit counter.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port clr  input  1  synchronous clear of progress, state and hits.
REQ-007 SHALL have port a  input  1  sampled event a.
REQ-008 SHALL have port b  input  1  sampled event b; ignored when KIND=0.
REQ-009 SHALL have port match  output  1  one-cycle pulse per completed pattern.
REQ-010 SHALL have port busy  output  1  high while a goto attempt is armed; constant 0 when KIND=0.
REQ-011 SHALL have port progress  output  4  current repetitions counted toward N.
REQ-012 SHALL have port hits  output  HIT_W  count of match pulses, saturating.

Function
REQ-013 SHALL register match: it is high in the cycle after the clock edge at which the completing sample is taken (latency 1).
REQ-014 KIND=0: progress SHALL increment on each edge sampling a=1, saturate at N, and go to 0 on an edge sampling a=0.
REQ-015 KIND=0: match SHALL assert after every edge at which progress was already N-1 or N and a=1, i.e. overlapping matches; a high for N+2 cycles gives 3 consecutive match pulses.
REQ-016 KIND=1: FSM states SHALL be IDLE and ARMED; reset and clr enter IDLE with progress=0.
REQ-017 KIND=1, IDLE: a=1 SHALL move to ARMED with progress=0; b sampled in that same cycle is not counted.
REQ-018 KIND=1, ARMED: each b=1 sample SHALL increment progress; a samples are ignored (non-reentrant, no second attempt).
REQ-019 KIND=1, ARMED: the sample making progress reach N SHALL return the FSM to IDLE, set progress to 0 and produce match; a in that same cycle does not re-arm.
REQ-020 KIND=1: a=1 in the first IDLE cycle after a match SHALL re-arm normally.
REQ-021 busy SHALL equal (state == ARMED).
REQ-022 hits SHALL increment once per match pulse and hold at 2^HIT_W-1.
REQ-023 clr SHALL take priority over a and b in the same cycle and SHALL force match to 0 on the following cycle.
REQ-024 N=1: KIND=0 matches after every a=1 sample; KIND=1 matches after the first b following the arming a.

Reset
REQ-025 While rst_n=0, match=0, busy=0, progress=0, hits=0 and FSM=IDLE, applied asynchronously.
REQ-026 Release of rst_n SHALL be honoured at the next rising edge; no event is counted on the releasing edge if rst_n is still 0 at that edge.
REQ-027 Reset asserted mid-attempt or mid-run SHALL discard all progress; no match pulse follows.

Verification
REQ-028 KIND=0, N=5: a=1 for 5 cycles, then 0 -> exactly one match pulse, 1 cycle after the 5th a; hits=1.
REQ-029 KIND=0, N=5: a=1 for 7 cycles -> 3 consecutive match pulses; hits=3; a=1,1,1,1,0,1 -> no match.
REQ-030 KIND=1, N=2: a at cycle 0, b at cycles 0, 5, 7 -> b at cycle 0 not counted; match after cycle 7; busy cycles 1..7.
REQ-031 KIND=1, N=2: a at cycle 0, a at cycle 3, b at cycles 4, 6, a at cycle 6 -> one match after cycle 6; no re-arm; busy=0 at cycle 7.
REQ-032 KIND=1, N=3: armed with progress=2, rst_n pulsed low -> progress=0, busy=0, no match; a later b alone -> no match.
REQ-033 HIT_W=2, KIND=0, N=1: a=1 for 6 cycles -> hits saturates at 3; clr then -> hits=0 and match=0 on the next cycle.
